mul_arb: RTL and testbench
==========================

MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, giving the operand width in bits.
REQ-002 The module SHALL have parameter LAT, default 2, giving the fixed cycles from issue to a valid MulProd; legal values are 1 to 4.
REQ-003 The ports SHALL be, in order:
  clk  in  1  clock
  reset  in  1  asynchronous, active-high reset
  Stall  in  1  freezes the shared multiplier pipeline
  Flush0  in  1  kills requester-0 operations in flight
  Req0Valid, Req1Valid  in  1  requester N has an operation
  Req0A, Req0B, Req1A, Req1B  in  XLEN  operands
  Req0Funct3, Req1Funct3  in  3  multiply type
  Req0Ready, Req1Ready  out  1  grant; the operation is accepted this cycle
  MulIssue  out  1  multiplier input is valid
  MulA, MulB  out  XLEN  granted operands
  MulFunct3  out  3  granted multiply type
  MulProd  in  2*XLEN  multiplier result
  Rsp0Valid, Rsp1Valid  out  1  result for requester N
  RspProd  out  2*XLEN  result data
REQ-004 Clocking SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-005 A grant SHALL occur only in a cycle with Stall=0 and at least one ReqNValid=1. At most one ReqNReady SHALL be 1 per cycle.
REQ-006 ReqNReady, MulIssue, MulA, MulB and MulFunct3 SHALL be combinational from the current inputs and state. While MulIssue=0, MulA, MulB and MulFunct3 SHALL be 0.
REQ-007 A handshake (ReqNValid=1 and ReqNReady=1) SHALL complete in one cycle. No input data is buffered.
REQ-008 A LAT-deep tag pipeline SHALL hold {valid, id} entries and advance on every clock with Stall=0. Entry 0 SHALL load {MulIssue, granted id}. While Stall=1, all entries SHALL hold.
REQ-009 RspNValid SHALL equal the last entry's valid AND (id==N) AND (Stall==0), so each operation produces exactly one response pulse.
REQ-010 RspProd SHALL pass MulProd through when either RspNValid is 1, and SHALL be 0 otherwise.
REQ-011 Responses SHALL have no backpressure, and responses SHALL be returned in issue order.
REQ-012 Flush0=1 SHALL clear valid on every tag entry with id=0 at the next edge, whether or not Stall is asserted.
REQ-013 Flush0=1 SHALL force Req0Ready=0 and Rsp0Valid=0 in the same cycle. Requester 1 SHALL be unaffected.
REQ-014 A LastGrant register SHALL update to the granted id on every grant and hold otherwise.
REQ-015 A single requester SHALL be granted back-to-back, one operation per cycle, with no bubble.
REQ-016 Throughput SHALL be one issue per unstalled cycle. At most LAT operations SHALL be in flight.

Reset
REQ-017 While reset=1, all tag entries SHALL be invalid and LastGrant SHALL be 1.
REQ-018 While reset=1, ReqNReady, MulIssue, RspNValid and RspProd SHALL be 0.
REQ-019 Operations in flight at reset SHALL be discarded and never produce a response. The first grant after reset SHALL go to requester 0 under contention.

Configuration
REQ-020 With macro MULARB_ROUNDROBIN_EN defined, simultaneous requests SHALL be granted to the requester not equal to LastGrant.
REQ-021 Without MULARB_ROUNDROBIN_EN, requester 0 SHALL always win. Requester 1 SHALL be granted only when Req0Valid=0 or Flush0=1.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (XLEN=64, LAT=2, the multiplier model is an ideal product):
- Single request: Req0 A=3, B=5, Funct3=000 in cycle 0 -> Req0Ready=1 and MulIssue=1 in cycle 0; Rsp0Valid=1 with RspProd=15 in cycle 2 only.
- Contention with MULARB_ROUNDROBIN_EN: both requesters valid for 6 cycles -> grants 0,1,0,1,0,1. Without the macro -> six grants to requester 0 and Req1Ready=0 throughout.
- Stall: Req1 A=7, B=6 at cycle 0, Stall=1 in cycles 1-3 -> no issue in cycles 1-3; a single Rsp1Valid pulse with RspProd=42 in cycle 5.
- Flush: Req0 issued in cycle 0 and Req1 in cycle 1, Flush0=1 in cycle 1 -> Rsp0Valid never asserts; Rsp1Valid=1 in cycle 3.
- Reset mid-operation: reset=1 in cycle 1 after an issue in cycle 0 -> no response afterwards. Both requesters valid after reset -> requester 0 is granted first.
- Back-to-back: Req1 issues 4 operations in cycles 0-3 with B=2 and A=1,2,3,4 -> Rsp1Valid in cycles 2-5 with RspProd 2,4,6,8 in order.

Source files
------------

// File: rtl/mul_arb.sv
// Arbiter that shares one pipelined multiplier between two requesters and routes results back by tag.
// Define MULARB_ROUNDROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mul_arb #(
  parameter int XLEN = 64,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              Flush0,
  input  logic              Req0Valid,
  input  logic              Req1Valid,
  input  logic [XLEN-1:0]   Req0A,
  input  logic [XLEN-1:0]   Req0B,
  input  logic [XLEN-1:0]   Req1A,
  input  logic [XLEN-1:0]   Req1B,
  input  logic [2:0]        Req0Funct3,
  input  logic [2:0]        Req1Funct3,
  output logic              Req0Ready,
  output logic              Req1Ready,
  output logic              MulIssue,
  output logic [XLEN-1:0]   MulA,
  output logic [XLEN-1:0]   MulB,
  output logic [2:0]        MulFunct3,
  input  logic [2*XLEN-1:0] MulProd,
  output logic              Rsp0Valid,
  output logic              Rsp1Valid,
  output logic [2*XLEN-1:0] RspProd
);

  // Handshake: an operation transfers in the cycle ReqNValid and ReqNReady are both 1;
  // responses are single-cycle pulses with no backpressure.
  logic [LAT-1:0] tag_v, tag_id;
  logic [LAT-1:0] nxt_v, nxt_id;
  logic           last_grant;
  logic           want0, want1, gnt0, gnt1;

  always_comb begin
    want0 = Req0Valid && !Flush0;
    want1 = Req1Valid;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!reset && !Stall) begin
`ifdef MULARB_ROUNDROBIN_EN
      if (want0 && want1) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = want0;
        gnt1 = want1;
      end
`else
      gnt0 = want0;
      gnt1 = want1 && !want0;
`endif
    end
  end

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;
  assign MulIssue  = gnt0 || gnt1;
  assign MulA      = gnt1 ? Req1A : (gnt0 ? Req0A : '0);
  assign MulB      = gnt1 ? Req1B : (gnt0 ? Req0B : '0);
  assign MulFunct3 = gnt1 ? Req1Funct3 : (gnt0 ? Req0Funct3 : 3'b000);

  // Stall gates the pulse so a frozen result is reported exactly once, on the cycle it leaves.
  assign Rsp0Valid = !reset && !Stall && !Flush0 && tag_v[LAT-1] && !tag_id[LAT-1];
  assign Rsp1Valid = !reset && !Stall && tag_v[LAT-1] && tag_id[LAT-1];
  assign RspProd   = (Rsp0Valid || Rsp1Valid) ? MulProd : '0;

  always_comb begin
    nxt_v  = tag_v;
    nxt_id = tag_id;
    if (!Stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        nxt_v[i]  = tag_v[i-1];
        nxt_id[i] = tag_id[i-1];
      end
      nxt_v[0]  = MulIssue;
      nxt_id[0] = gnt1;
    end
    // Flush kills requester-0 work even while the pipeline is frozen.
    if (Flush0) begin
      for (int i = 0; i < LAT; i++) begin
        if (!nxt_id[i]) nxt_v[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v      <= '0;
      tag_id     <= '0;
      last_grant <= 1'b1;
    end else begin
      tag_v  <= nxt_v;
      tag_id <= nxt_id;
      if (MulIssue && (last_grant != gnt1)) last_grant <= gnt1;
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb: a per-cycle vector table plus hand-written reset sequences,
// with an ideal LAT-stage multiplier model feeding MulProd.
module tb_mul_arb;
  localparam int XLEN = 64;
  localparam int LAT  = 2;
`ifdef MULARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk, reset, Stall, Flush0;
  logic              Req0Valid, Req1Valid;
  logic [XLEN-1:0]   Req0A, Req0B, Req1A, Req1B;
  logic [2:0]        Req0Funct3, Req1Funct3;
  logic              Req0Ready, Req1Ready, MulIssue;
  logic [XLEN-1:0]   MulA, MulB;
  logic [2:0]        MulFunct3;
  logic [2*XLEN-1:0] MulProd;
  logic              Rsp0Valid, Rsp1Valid;
  logic [2*XLEN-1:0] RspProd;

  int n_checks = 0;
  int n_fail   = 0;

  mul_arb #(.XLEN(XLEN), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush0(Flush0),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0A(Req0A), .Req0B(Req0B), .Req1A(Req1A), .Req1B(Req1B),
    .Req0Funct3(Req0Funct3), .Req1Funct3(Req1Funct3),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .MulIssue(MulIssue), .MulA(MulA), .MulB(MulB), .MulFunct3(MulFunct3),
    .MulProd(MulProd), .Rsp0Valid(Rsp0Valid), .Rsp1Valid(Rsp1Valid),
    .RspProd(RspProd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ideal multiplier: LAT stages, frozen by Stall
  logic [2*XLEN-1:0] pipe [LAT];
  always_ff @(posedge clk) begin
    if (!Stall) begin
      pipe[0] <= {{XLEN{1'b0}}, MulA} * {{XLEN{1'b0}}, MulB};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign MulProd = pipe[LAT-1];

  typedef struct {
    logic            st, fl, v0;
    logic [XLEN-1:0] a0, b0;
    logic            v1;
    logic [XLEN-1:0] a1, b1;
    logic            r0, r1, iss;
    logic [XLEN-1:0] mula;
    logic            rs0, rs1;
    logic [2*XLEN-1:0] prod;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic fl,
                              input logic v0, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
                              input logic v1, input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1,
                              input logic r0, input logic r1, input logic iss,
                              input logic [XLEN-1:0] mula, input logic rs0, input logic rs1,
                              input logic [2*XLEN-1:0] prod);
    vec_t v;
    v.st = st; v.fl = fl; v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.r0 = r0; v.r1 = r1; v.iss = iss; v.mula = mula;
    v.rs0 = rs0; v.rs1 = rs1; v.prod = prod;
    return v;
  endfunction

  // scoreboard check
  task automatic chk(input string name, input logic [2*XLEN-1:0] act, input logic [2*XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    Stall = v.st; Flush0 = v.fl;
    Req0Valid = v.v0; Req0A = v.a0; Req0B = v.b0;
    Req1Valid = v.v1; Req1A = v.a1; Req1B = v.b1;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, "_req0ready"}, {127'b0, Req0Ready}, {127'b0, v.r0});
    chk({tag, "_req1ready"}, {127'b0, Req1Ready}, {127'b0, v.r1});
    chk({tag, "_mulissue"},  {127'b0, MulIssue},  {127'b0, v.iss});
    chk({tag, "_mula"},      {64'b0, MulA},       {64'b0, v.mula});
    chk({tag, "_rsp0valid"}, {127'b0, Rsp0Valid}, {127'b0, v.rs0});
    chk({tag, "_rsp1valid"}, {127'b0, Rsp1Valid}, {127'b0, v.rs1});
    chk({tag, "_rspprod"},   RspProd,             v.prod);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req0ready"}, {127'b0, Req0Ready}, '0);
    chk({tag, "_req1ready"}, {127'b0, Req1Ready}, '0);
    chk({tag, "_mulissue"},  {127'b0, MulIssue},  '0);
    chk({tag, "_rsp0valid"}, {127'b0, Rsp0Valid}, '0);
    chk({tag, "_rsp1valid"}, {127'b0, Rsp1Valid}, '0);
    chk({tag, "_rspprod"},   RspProd,             '0);
  endtask

  initial begin
    int g, gp;
    logic v, rsp;

    // contention first, so LastGrant still holds its reset value of 1
    for (int k = 0; k < 8; k++) begin
      v   = (k < 6);
      rsp = (k >= 2);
      g   = RR ? (k % 2) : 0;
      gp  = RR ? ((k + 2) % 2) : 0;
      tbl.push_back(mk(0, 0, v, 2, 3, v, 4, 5,
                       v && (g == 0), v && (g == 1), v, v ? ((g == 1) ? 64'd4 : 64'd2) : 64'd0,
                       rsp && (gp == 0), rsp && (gp == 1),
                       rsp ? ((gp == 1) ? 128'd20 : 128'd6) : 128'd0));
    end
    // single request, response in cycle 2 only
    tbl.push_back(mk(0, 0, 1, 3, 5, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 15));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // stall: issue in 0, frozen 1-3 with req0 waiting, response in 5
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 6, 0, 1, 1, 7, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 42));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // flush: req0 in 0, req1 (granted past a flushed req0) in 1
    tbl.push_back(mk(0, 0, 1, 9, 9, 0, 0, 0, 1, 0, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 9, 9, 1, 7, 3, 0, 1, 1, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 21));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // flush on the response cycle suppresses Rsp0Valid
    tbl.push_back(mk(0, 0, 1, 3, 3, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // back-to-back from requester 1
    for (int k = 0; k < 7; k++) begin
      v   = (k < 4);
      rsp = (k >= 2) && (k < 6);
      tbl.push_back(mk(0, 0, 0, 0, 0, v, v ? 64'(k + 1) : 64'd0, v ? 64'd2 : 64'd0,
                       0, v, v, v ? 64'(k + 1) : 64'd0,
                       0, rsp, rsp ? 128'(2 * (k - 1)) : 128'd0));
    end

    // reset state with both requesters asking
    reset = 1'b1;
    Req0Funct3 = 3'b000;
    Req1Funct3 = 3'b000;
    drive(mk(0, 0, 1, 3, 5, 1, 7, 6, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin
      @(negedge clk);
      check_quiet("reset");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      #4;
      check_row($sformatf("row%0d", i), tbl[i]);
    end

    // reset while an operation is in flight
    @(posedge clk); #1;
    drive(mk(0, 0, 1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #4;
    chk("midrst_issue", {127'b0, MulIssue}, 128'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(mk(0, 0, 1, 3, 5, 1, 7, 6, 0, 0, 0, 0, 0, 0, 0));
    #4;
    check_quiet("midrst_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_rsp0_c%0d", k), {127'b0, Rsp0Valid}, '0);
      chk($sformatf("midrst_rsp1_c%0d", k), {127'b0, Rsp1Valid}, '0);
    end
    @(posedge clk); #1;
    drive(mk(0, 0, 1, 1, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    #4;
    chk("postrst_req0ready", {127'b0, Req0Ready}, 128'd1);
    chk("postrst_req1ready", {127'b0, Req1Ready}, 128'd0);
    chk("postrst_mula",      {64'b0, MulA},       128'd1);
    @(posedge clk); #1;
    idle();
    repeat (3) @(posedge clk);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
